// File: rtl/ext_mem_loader_pkg.sv
// Shared definitions for the external memory loader: session FSM states,
// memory byte strides and the zero-count skip helper.
package ext_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_I = 3'd1,
        ST_LOAD_D = 3'd2,
        ST_RUN    = 3'd3,
        ST_DUMP   = 3'd4,
        ST_DONE   = 3'd5
    } ldr_state_t;

    localparam logic [63:0] IMEM_STRIDE = 64'd4;
    localparam logic [63:0] DMEM_STRIDE = 64'd8;

    // Walks forward from 'from' past every phase whose count is zero, so a
    // session can fall through several empty phases in a single cycle.
    function automatic ldr_state_t first_active(input ldr_state_t from,
                                                input logic nz_i, input logic nz_d,
                                                input logic nz_r, input logic nz_u);
        ldr_state_t s;
        s = from;
        if (s == ST_LOAD_I && !nz_i) s = ST_LOAD_D;
        if (s == ST_LOAD_D && !nz_d) s = ST_RUN;
        if (s == ST_RUN    && !nz_r) s = ST_DUMP;
        if (s == ST_DUMP   && !nz_u) s = ST_DONE;
        return s;
    endfunction

endpackage

// File: rtl/ext_mem_loader_rd_skid.sv
// Single-entry 64-bit output register for the readback stream. Accepts a
// word when empty or when the held word is being taken in the same cycle.
module ext_rd_skid (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [63:0] i_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [63:0] o_data
);

    logic        r_valid;
    logic [63:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid <= 1'b0;
            r_data  <= 64'h0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ext_mem_loader.sv
// Session sequencer: streams words into instruction and data SRAMs, runs the
// CPU for a fixed number of cycles, then streams data words back out.
module ext_mem_loader
    import ext_mem_loader_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [63:0] DMEM_BASE = 64'h0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_imem,
    input  logic [CNT_W-1:0] n_dmem,
    input  logic [CNT_W-1:0] n_dump,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    // Streams: a word moves on a rising edge where valid and ready are both
    // high; the readback side holds m_valid and m_data steady until taken.

    ldr_state_t       r_state, w_next;
    logic [CNT_W-1:0] r_n_imem, r_n_dmem, r_n_dump, r_run;
    logic [CNT_W-1:0] r_cnt, r_rd_cnt;
    logic             r_inflight;
    logic             w_m_xfer, w_cnt_step, w_rd_issue, w_skid_rdy;
    logic             w_unused_rdata;

    assign w_unused_rdata = ^rdata_ext;
    assign dbg_state      = r_state;
    assign w_m_xfer       = m_valid && m_ready;
    assign w_cnt_step     = ((r_state == ST_LOAD_I || r_state == ST_LOAD_D) && s_valid)
                          || (r_state == ST_RUN)
                          || (r_state == ST_DUMP && w_m_xfer);
    // A new read may only launch when its data is guaranteed a slot next cycle.
    assign w_rd_issue     = (r_state == ST_DUMP) && (r_rd_cnt < r_n_dump)
                          && !r_inflight && w_skid_rdy;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_n_imem   <= '0;
            r_n_dmem   <= '0;
            r_n_dump   <= '0;
            r_run      <= '0;
            r_cnt      <= '0;
            r_rd_cnt   <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_n_imem <= n_imem;
                r_n_dmem <= n_dmem;
                r_n_dump <= n_dump;
                r_run    <= run_cycles;
            end
            if (w_next != r_state) r_cnt <= '0;
            else if (w_cnt_step)   r_cnt <= r_cnt + CNT_W'(1);
            if (r_state != ST_DUMP) r_rd_cnt <= '0;
            else if (w_rd_issue)    r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            r_inflight <= w_rd_issue;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start)
                           w_next = first_active(ST_LOAD_I, n_imem != '0, n_dmem != '0,
                                                 run_cycles != '0, n_dump != '0);
            ST_LOAD_I: if (s_valid && r_cnt == r_n_imem - CNT_W'(1))
                           w_next = first_active(ST_LOAD_D, 1'b1, r_n_dmem != '0,
                                                 r_run != '0, r_n_dump != '0);
            ST_LOAD_D: if (s_valid && r_cnt == r_n_dmem - CNT_W'(1))
                           w_next = first_active(ST_RUN, 1'b1, 1'b1,
                                                 r_run != '0, r_n_dump != '0);
            ST_RUN:    if (r_cnt == r_run - CNT_W'(1))
                           w_next = first_active(ST_DUMP, 1'b1, 1'b1, 1'b1, r_n_dump != '0);
            ST_DUMP:   if (w_m_xfer && r_cnt == r_n_dump - CNT_W'(1))
                           w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready     = 1'b0;
        cpu_enable  = 1'b0;
        addr_ext    = 64'h0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        wdata_ext   = 32'h0;
        addr_ext_2  = 64'h0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = 64'h0;
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        case (r_state)
            ST_LOAD_I: begin
                s_ready   = 1'b1;
                addr_ext  = 64'(r_cnt) * IMEM_STRIDE;
                wen_ext   = s_valid;
                wdata_ext = s_data[31:0];
            end
            ST_LOAD_D: begin
                s_ready     = 1'b1;
                addr_ext_2  = DMEM_BASE + 64'(r_cnt) * DMEM_STRIDE;
                wen_ext_2   = s_valid;
                wdata_ext_2 = s_data;
            end
            ST_RUN:  cpu_enable = 1'b1;
            ST_DUMP: begin
                addr_ext_2 = DMEM_BASE + 64'(r_rd_cnt) * DMEM_STRIDE;
                ren_ext_2  = w_rd_issue;
            end
            default: ;
        endcase
    end

    ext_rd_skid u_rd_skid (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_valid (r_inflight),
        .o_ready (w_skid_rdy),
        .i_data  (rdata_ext_2),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_data  (m_data)
    );

endmodule

// File: tb/tb_ext_mem_loader.sv
// Bench for ext_mem_loader: table of load/run/dump sessions with a scoreboard
// on every memory write and readback word, plus zero-count and abort sequences.
module tb_ext_mem_loader;

    localparam logic [63:0] TB_BASE = 64'h0000_0000_0000_1000;

    logic        clk, arst_n, start;
    logic [15:0] n_imem, n_dmem, n_dump, run_cycles;
    logic        s_valid, s_ready, m_valid, m_ready, cpu_enable;
    logic [63:0] s_data, m_data, addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
    logic [31:0] wdata_ext, rdata_ext;
    logic [2:0]  dbg_state;

    ext_mem_loader #(.CNT_W(16), .DMEM_BASE(TB_BASE)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .n_imem(n_imem), .n_dmem(n_dmem), .n_dump(n_dump), .run_cycles(run_cycles),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    logic [63:0] dmem_model [64];
    logic [63:0] rd_q = 64'h0;
    assign rdata_ext   = 32'h0;
    assign rdata_ext_2 = rd_q;

    function automatic logic [5:0] didx(input logic [63:0] a);
        logic [63:0] o;
        o = (a - TB_BASE) >> 3;
        return o[5:0];
    endfunction

    always @(posedge clk) begin
        if (wen_ext_2) dmem_model[didx(addr_ext_2)] <= wdata_ext_2;
        if (ren_ext_2) rd_q <= dmem_model[didx(addr_ext_2)];
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [95:0]  exp_i_q[$];
    logic [127:0] exp_d_q[$];
    logic [63:0]  exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: output with empty expected queue", name);
    endtask

    int n_wi, n_wd, n_cpu, n_cpu_rise, n_mx, n_done, viol;
    logic prev_cpu = 1'b0, stall_prev = 1'b0;
    logic [63:0] prev_data;

    always @(negedge clk) begin
        if (!arst_n) begin
            stall_prev = 1'b0;
            prev_cpu   = 1'b0;
        end else begin
            if (wen_ext) begin
                n_wi++;
                if (exp_i_q.size() == 0) unexpected("imem_write");
                else chk("imem_write", {addr_ext, wdata_ext}, exp_i_q.pop_front());
            end
            if (wen_ext_2) begin
                n_wd++;
                if (exp_d_q.size() == 0) unexpected("dmem_write");
                else chk("dmem_write", {addr_ext_2, wdata_ext_2}, exp_d_q.pop_front());
            end
            if (stall_prev) begin
                chk("m_hold_valid", m_valid, 1'b1);
                chk("m_hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                n_mx++;
                if (exp_q.size() == 0) unexpected("readback");
                else chk("readback", m_data, exp_q.pop_front());
            end
            if (cpu_enable) n_cpu++;
            if (cpu_enable && !prev_cpu) n_cpu_rise++;
            if (done) n_done++;
            if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2)) viol++;
            if ((cpu_enable || !busy || done) && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) viol++;
            if (cpu_enable && !busy) viol++;
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_cpu   = cpu_enable;
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        logic [15:0] n_imem, n_dmem, run, n_dump;
        int s_mode, m_mode;
        int exp_wi, exp_wd, exp_cpu, exp_mx;
    } vec_t;

    vec_t tbl[8];
    logic [6:0] m_pat = 7'b1011001;

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {cpu_enable, s_ready, m_valid, wen_ext, ren_ext,
                             wen_ext_2, ren_ext_2, busy, done}, 0);
        chk({tag, "_addr"}, {addr_ext, addr_ext_2}, 0);
        chk({tag, "_wdata"}, {wdata_ext, wdata_ext_2}, 0);
        chk({tag, "_mdata"}, m_data, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic run_session(input int id, input vec_t v, input bit abort);
        int widx, cyc, total, k;
        bit sess_done;
        string tag;
        tag = $sformatf("sess%0d", id);
        total = int'(v.n_imem) + int'(v.n_dmem);
        n_wi = 0; n_wd = 0; n_cpu = 0; n_cpu_rise = 0; n_mx = 0; n_done = 0;
        n_imem = v.n_imem; n_dmem = v.n_dmem; run_cycles = v.run; n_dump = v.n_dump;
        start = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        widx = 0; cyc = 0; sess_done = 0;
        while (!sess_done && cyc < 600) begin
            if (cyc == 2) begin
                start = 1'b1;
                n_imem = 16'($urandom_range(1, 20)); n_dmem = 16'($urandom_range(1, 20));
                run_cycles = 16'($urandom_range(1, 20)); n_dump = 16'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
            case (v.s_mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            if (widx >= total) s_valid = 1'b0;
            s_data = {$urandom, $urandom};
            if (s_valid && s_ready) begin
                if (widx < int'(v.n_imem)) begin
                    exp_i_q.push_back({64'(widx) * 64'd4, s_data[31:0]});
                end else begin
                    k = widx - int'(v.n_imem);
                    exp_d_q.push_back({TB_BASE + 64'(k) * 64'd8, s_data});
                    if (k < int'(v.n_dump)) exp_q.push_back(s_data);
                end
                widx++;
            end
            case (v.m_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = m_pat[cyc % 7];
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
            @(negedge clk);
            if (done) sess_done = 1;
            if (abort && ren_ext_2) begin
                @(posedge clk); #1;
                arst_n = 1'b0;
                @(negedge clk);
                check_reset_outputs({tag, "_abort"});
                @(posedge clk); #1;
                arst_n = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
                exp_q.delete();
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk({tag, "_post_abort_mvalid"}, m_valid, 1'b0);
                chk({tag, "_post_abort_busy"}, busy, 1'b0);
                sess_done = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        if (!sess_done) begin
            failures++; checks++;
            $display("FAIL %s_timeout: no done after %0d cycles", tag, cyc);
        end
        if (!abort) begin
            chk({tag, "_imem_writes"}, n_wi, v.exp_wi);
            chk({tag, "_dmem_writes"}, n_wd, v.exp_wd);
            chk({tag, "_cpu_cycles"}, n_cpu, v.exp_cpu);
            chk({tag, "_cpu_bursts"}, n_cpu_rise, (v.exp_cpu > 0) ? 1 : 0);
            chk({tag, "_readback_words"}, n_mx, v.exp_mx);
            chk({tag, "_done_pulses"}, n_done, 1);
            chk({tag, "_idle_after"}, busy, 1'b0);
        end
        chk({tag, "_exp_i_left"}, exp_i_q.size(), 0);
        chk({tag, "_exp_d_left"}, exp_d_q.size(), 0);
        chk({tag, "_exp_rb_left"}, exp_q.size(), 0);
        exp_i_q.delete(); exp_d_q.delete(); exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t ab;
        arst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 64'h0;
        n_imem = 16'd0; n_dmem = 16'd0; n_dump = 16'd0; run_cycles = 16'd0;
        n_wi = 0; n_wd = 0; n_cpu = 0; n_cpu_rise = 0; n_mx = 0; n_done = 0; viol = 0;

        tbl[0] = '{16'd3, 16'd0, 16'd0, 16'd0, 0, 0, 3, 0, 0, 0};
        tbl[1] = '{16'd0, 16'd2, 16'd0, 16'd0, 1, 0, 0, 2, 0, 0};
        tbl[2] = '{16'd0, 16'd0, 16'd5, 16'd0, 0, 0, 0, 0, 5, 0};
        tbl[3] = '{16'd0, 16'd4, 16'd0, 16'd4, 0, 1, 0, 4, 0, 4};
        tbl[4] = '{16'd2, 16'd3, 16'd3, 16'd3, 2, 2, 2, 3, 3, 3};
        tbl[5] = '{16'd5, 16'd6, 16'd2, 16'd5, 1, 2, 5, 6, 2, 5};
        tbl[6] = '{16'd1, 16'd1, 16'd1, 16'd1, 0, 0, 1, 1, 1, 1};
        tbl[7] = '{16'd4, 16'd4, 16'd0, 16'd2, 2, 1, 4, 4, 0, 2};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_session(i, tbl[i], 1'b0);
            @(posedge clk); #1;
        end

        // All counts zero: IDLE -> DONE -> IDLE.
        n_imem = 16'd0; n_dmem = 16'd0; run_cycles = 16'd0; n_dump = 16'd0;
        start = 1'b1;
        @(negedge clk);
        chk("zero_start_cycle_busy", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done_pulse", done, 1'b1);
        chk("zero_done_busy", busy, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_done_low", done, 1'b0);
        chk("zero_back_idle", busy, 1'b0);
        @(posedge clk); #1;

        // Reset while a readback word is in flight.
        ab = '{16'd0, 16'd2, 16'd0, 16'd2, 0, 3, 0, 2, 0, 0};
        run_session(8, ab, 1'b1);
        @(posedge clk); #1;

        chk("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
